// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through IDLE/ADDR/REQ under scheduler strobes,
// runs a ROM read handshake with timeout, and halts on a halt word, limit or timeout.
module fetch_unit #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [31:0] PROG_LIMIT  = 32'h0000_0400,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned ROM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enableGetPC,
  input  logic        enableRomRead,
  input  logic        enableIncPC,
  input  logic        enableBX,
  input  logic [31:0] branchTarget,
  output logic [31:0] romAddr,
  output logic        romReq,
  input  logic        romAck,
  input  logic [31:0] romData,
  output logic [31:0] instruction,
  output logic [31:0] pcOut,
  output logic        fetchValid,
  output logic        doneProc,
  output logic        fetchErr
);

  typedef enum logic [1:0] {StIdle, StAddr, StReq, StHalt} state_e;
  typedef enum logic [2:0] {CmdNone, CmdGetPc, CmdRomRead, CmdIncPc, CmdBx} cmd_e;

  localparam logic [7:0] TimeoutLast = 8'(ROM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic        rom_req_q, rom_req_d;
  logic [31:0] instr_q, instr_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  cmd_e        cmd;

  // Branch targets are word aligned; the low bits are intentionally dropped.
  logic unused_bt;
  assign unused_bt = ^branchTarget[1:0];

  // Only the highest-priority strobe is considered; if it is illegal, nothing happens.
  always_comb begin
    cmd = CmdNone;
    if (enableBX)           cmd = CmdBx;
    else if (enableIncPC)   cmd = CmdIncPc;
    else if (enableRomRead) cmd = CmdRomRead;
    else if (enableGetPC)   cmd = CmdGetPc;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rom_addr_d    = rom_addr_q;
    rom_req_d     = rom_req_q;
    instr_d       = instr_q;
    fetch_valid_d = fetch_valid_q;
    done_d        = done_q;
    err_d         = err_q;
    cnt_d         = cnt_q;

    case (state_q)
      StIdle, StAddr: begin
        case (cmd)
          CmdBx: begin
            pc_d          = {branchTarget[31:2], 2'b00};
            fetch_valid_d = 1'b0;
            state_d       = StIdle;
          end
          CmdIncPc: begin
            pc_d          = pc_q + 32'd4;
            fetch_valid_d = 1'b0;
            state_d       = StIdle;
          end
          CmdRomRead: begin
            if (state_q == StAddr) begin
              rom_req_d = 1'b1;
              cnt_d     = 8'd0;
              state_d   = StReq;
            end
          end
          CmdGetPc: begin
            if (state_q == StIdle) begin
              if (pc_q < PROG_LIMIT) begin
                rom_addr_d    = pc_q;
                fetch_valid_d = 1'b0;
                state_d       = StAddr;
              end else begin
                done_d  = 1'b1;
                state_d = StHalt;
              end
            end
          end
          default: ;
        endcase
      end
      StReq: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (romAck) begin
          instr_d   = romData;
          rom_req_d = 1'b0;
          if (romData == HALT_WORD) begin
            fetch_valid_d = 1'b0;
            done_d        = 1'b1;
            state_d       = StHalt;
          end else begin
            fetch_valid_d = 1'b1;
            state_d       = StIdle;
          end
        end else if (cnt_q == TimeoutLast) begin
          rom_req_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHalt: begin
        rom_req_d = 1'b0;
        done_d    = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= PC_RESET;
      rom_addr_q    <= PC_RESET;
      rom_req_q     <= 1'b0;
      instr_q       <= 32'd0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_addr_q    <= rom_addr_d;
      rom_req_q     <= rom_req_d;
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign romAddr     = rom_addr_q;
  assign romReq      = rom_req_q;
  assign instruction = instr_q;
  assign pcOut       = pc_q;
  assign fetchValid  = fetch_valid_q;
  assign doneProc    = done_q;
  assign fetchErr    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a randomized
// run checked against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;
  localparam logic [31:0] Limit    = 32'h0000_0400;
  localparam int          Timeout  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_w = 1'b0;
  logic        en_get = 1'b0, en_rd = 1'b0, en_inc = 1'b0, en_bx = 1'b0;
  logic [31:0] bt = '0;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_data = '0;

  logic [31:0] rom_addr, instr, pc_out;
  logic        rom_req, fetch_valid, done_proc, fetch_err;
  logic [31:0] rom_addr_w, instr_w, pc_out_w;
  logic        rom_req_w, fetch_valid_w, done_proc_w, fetch_err_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .enableGetPC(en_get), .enableRomRead(en_rd), .enableIncPC(en_inc), .enableBX(en_bx),
    .branchTarget(bt), .romAddr(rom_addr), .romReq(rom_req), .romAck(rom_ack),
    .romData(rom_data), .instruction(instr), .pcOut(pc_out), .fetchValid(fetch_valid),
    .doneProc(done_proc), .fetchErr(fetch_err)
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFFC), .PROG_LIMIT(32'h0000_0000)) u_wrap (
    .clk(clk), .rst_n(rst_w),
    .enableGetPC(en_get), .enableRomRead(en_rd), .enableIncPC(en_inc), .enableBX(en_bx),
    .branchTarget(bt), .romAddr(rom_addr_w), .romReq(rom_req_w), .romAck(rom_ack),
    .romData(rom_data), .instruction(instr_w), .pcOut(pc_out_w), .fetchValid(fetch_valid_w),
    .doneProc(done_proc_w), .fetchErr(fetch_err_w)
  );

  // Behavioural model: flags describe where the fetch handshake stands.
  logic [31:0] m_pc, m_addr, m_ins;
  logic        m_req, m_valid, m_done, m_err;
  bit          m_ready, m_wait, m_halt;
  int          m_waited;

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_ins = 32'h0;
    m_req = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_ready = 1'b0; m_wait = 1'b0; m_halt = 1'b0; m_waited = 0;
  endtask

  task automatic model_step();
    if (m_halt) return;
    if (m_wait) begin
      m_waited++;
      if (rom_ack) begin
        m_ins = rom_data; m_req = 1'b0; m_wait = 1'b0;
        if (rom_data == HaltWord) begin
          m_valid = 1'b0; m_done = 1'b1; m_halt = 1'b1;
        end else begin
          m_valid = 1'b1;
        end
      end else if (m_waited == Timeout) begin
        m_req = 1'b0; m_err = 1'b1; m_done = 1'b1; m_wait = 1'b0; m_halt = 1'b1;
      end
    end else if (en_bx) begin
      m_pc = bt & 32'hFFFF_FFFC; m_valid = 1'b0; m_ready = 1'b0;
    end else if (en_inc) begin
      m_pc = m_pc + 32'd4; m_valid = 1'b0; m_ready = 1'b0;
    end else if (en_rd) begin
      if (m_ready) begin
        m_req = 1'b1; m_wait = 1'b1; m_waited = 0; m_ready = 1'b0;
      end
    end else if (en_get && !m_ready) begin
      if (m_pc < Limit) begin
        m_addr = m_pc; m_valid = 1'b0; m_ready = 1'b1;
      end else begin
        m_done = 1'b1; m_halt = 1'b1;
      end
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] e_pc, input logic [31:0] e_addr,
                           input logic e_req, input logic [31:0] e_ins, input logic e_v,
                           input logic e_d, input logic e_e);
    logic [99:0] act, exp;
    act = {pc_out, rom_addr, instr, rom_req, fetch_valid, done_proc, fetch_err};
    exp = {e_pc, e_addr, e_ins, e_req, e_v, e_d, e_e};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got pc=%h addr=%h ins=%h req/v/done/err=%b%b%b%b, want pc=%h addr=%h ins=%h req/v/done/err=%b%b%b%b",
               name, $time, pc_out, rom_addr, instr, rom_req, fetch_valid, done_proc, fetch_err,
               e_pc, e_addr, e_ins, e_req, e_v, e_d, e_e);
    end
  endtask

  task automatic check_model(input string name);
    check_out(name, m_pc, m_addr, m_req, m_ins, m_valid, m_done, m_err);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with outputs settled after one posedge.
  task automatic step(input logic g, input logic r, input logic i, input logic b,
                      input logic [31:0] t, input logic a, input logic [31:0] d);
    en_get = g; en_rd = r; en_inc = i; en_bx = b; bt = t; rom_ack = a; rom_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asserted mid-cycle so the asynchronous path is what clears the outputs.
  task automatic do_reset();
    en_get = 1'b0; en_rd = 1'b0; en_inc = 1'b0; en_bx = 1'b0; rom_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_out("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        g, r, i, b;
    logic [31:0] t;
    logic        a;
    logic [31:0] d;
    logic [31:0] e_pc, e_addr;
    logic        e_req;
    logic [31:0] e_ins;
    logic        e_v, e_d, e_e;
  } vec_t;

  vec_t tbl[17];
  logic g, r, i, b, a;
  logic [31:0] t, d;

  initial begin
    // Fetch, increment, branch, priority, illegal strobes, halt word.
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h0,   1'b0, 32'h0,         1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h0,   1'b1, 32'h0,         1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h0,   1'b1, 32'h0,         1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h0,   1'b1, 32'h0,         1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   1'b1, 32'hE3A0_0001, 32'h0,   32'h0,   1'b0, 32'hE3A0_0001, 1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 32'h0,   1'b0, 32'h0,         32'h4,   32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 32'h0,   1'b0, 32'h0,         32'h8,   32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1, 32'h123, 1'b0, 32'h0,         32'h120, 32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b1, 32'h200, 1'b0, 32'h0,         32'h200, 32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h200, 32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   1'b1, 32'hDEAD_BEEF, 32'h200, 32'h0,   1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h200, 32'h200, 1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h200, 32'h200, 1'b0, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0, 32'h0,   1'b0, 32'h0,         32'h200, 32'h200, 1'b1, 32'hE3A0_0001, 1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b1, 32'h40,  1'b1, 32'hFFFF_FFFF, 32'h200, 32'h200, 1'b0, 32'hFFFF_FFFF, 1'b0,1'b1,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   1'b1, 32'h0,         32'h200, 32'h200, 1'b0, 32'hFFFF_FFFF, 1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b1,1'b1, 32'h10,  1'b0, 32'h0,         32'h200, 32'h200, 1'b0, 32'hFFFF_FFFF, 1'b0,1'b1,1'b0};

    @(negedge clk);
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].g, tbl[k].r, tbl[k].i, tbl[k].b, tbl[k].t, tbl[k].a, tbl[k].d);
      check_out($sformatf("table[%0d]", k), tbl[k].e_pc, tbl[k].e_addr, tbl[k].e_req,
                tbl[k].e_ins, tbl[k].e_v, tbl[k].e_d, tbl[k].e_e);
    end

    // Timeout: romReq high for exactly Timeout cycles, then sticky error.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k <= Timeout; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check1($sformatf("timeout_req[%0d]", k), {31'd0, rom_req}, (k < Timeout) ? 32'd1 : 32'd0);
    end
    check_out("timeout_end", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    check_out("timeout_absorb", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Ack in the expiry cycle completes normally.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(Timeout - 1);
    check1("ack_late_req", {31'd0, rom_req}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    check_out("ack_at_expiry", 32'h0, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);

    // Program limit: GetPC outside program space halts without a ROM request.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_out("limit_get", 32'h400, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_out("limit_rd", 32'h400, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // PC wrap on the second instance (PC_RESET=FFFF_FFFC, PROG_LIMIT=0).
    do_reset();
    rst_w = 1'b1;
    check1("wrap_reset_pc", pc_out_w, 32'hFFFF_FFFC);
    check1("wrap_reset_addr", rom_addr_w, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check1("wrap_inc", pc_out_w, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check1("wrap_limit_done", {30'd0, done_proc_w, rom_req_w}, 32'd2);
    rst_w = 1'b0;

    // Reset in the middle of a ROM request, then a stray ack.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_out("pre_reset_req", 32'h10, 32'h10, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0000);
    check_out("stray_ack", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (m_halt || $urandom_range(0, 199) == 0) do_reset();
      g = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 9) < 4);
      i = ($urandom_range(0, 9) < 2);
      b = ($urandom_range(0, 9) < 1);
      t = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h3FF));
      a = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 15) == 0) ? HaltWord : 32'($urandom);
      step(g, r, i, b, t, a, d);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
